// File: rtl/systolic_pkg.sv
// Shared types and default sizes for the systolic array,
// its result mux and the result drain controller.
package systolic_pkg;

  localparam int DEF_DATAWIDTH = 16;
  localparam int DEF_N_INPUTS  = 8;
  localparam int DEF_SELWIDTH  = 3;
  localparam int DEF_CNTWIDTH  = 4;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DONE
  } drain_state_t;

endpackage

// File: rtl/result_drain_ctrl_mux.sv
// Word select mux: presents one result word
// of the bank chosen by sel.
module result_drain_ctrl_mux
  import systolic_pkg::*;
#(
  parameter int DATAWIDTH = DEF_DATAWIDTH,
  parameter int N_INPUTS  = DEF_N_INPUTS,
  parameter int SELWIDTH  = DEF_SELWIDTH
) (
  input  logic [N_INPUTS-1:0][DATAWIDTH-1:0] in_array,
  input  logic [SELWIDTH-1:0]                sel,
  output logic [DATAWIDTH-1:0]               out
);

  assign out = in_array[sel];

endmodule

// File: rtl/result_drain_ctrl.sv
// Snapshots one batch of array results and drains it
// word by word onto a valid/ready output stream.
module result_drain_ctrl
  import systolic_pkg::*;
#(
  parameter int DATAWIDTH = DEF_DATAWIDTH,
  parameter int N_INPUTS  = DEF_N_INPUTS,
  parameter int SELWIDTH  = DEF_SELWIDTH,
  parameter int CNTWIDTH  = DEF_CNTWIDTH
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [N_INPUTS-1:0][DATAWIDTH-1:0] in_array,
  input  logic                               start,
  input  logic [CNTWIDTH-1:0]                num_words,
  output logic [DATAWIDTH-1:0]               out_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [SELWIDTH-1:0]                sel,
  output logic                               busy,
  output logic                               done
);

  drain_state_t state, state_d;

  logic [SELWIDTH-1:0] idx, idx_d;
  logic [CNTWIDTH-1:0] cnt, cnt_d;
  logic [CNTWIDTH-1:0] nw_clamp;
  logic                load;
  logic                last;

  logic [N_INPUTS-1:0][DATAWIDTH-1:0] bank;

  assign nw_clamp = (num_words > CNTWIDTH'(N_INPUTS))
                  ? CNTWIDTH'(N_INPUTS) : num_words;

  assign last = (CNTWIDTH'(idx) == cnt - CNTWIDTH'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_d;
      idx   <= idx_d;
      cnt   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank <= '0;
    end else if (load) begin
      bank <= in_array;
    end
  end

  always_comb begin
    state_d = state;
    idx_d   = idx;
    cnt_d   = cnt;
    load    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          cnt_d   = nw_clamp;
          idx_d   = '0;
          state_d = (nw_clamp == '0) ? DONE : STREAM;
        end
      end
      STREAM: begin
        if (out_ready) begin
          if (last) state_d = DONE;
          else      idx_d   = idx + SELWIDTH'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        idx_d   = '0;
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Status outputs decode the registered state only.
  assign out_valid = (state == STREAM);
  assign done      = (state == DONE);
  assign busy      = (state != IDLE);
  assign sel       = idx;

  result_drain_ctrl_mux #(
    .DATAWIDTH (DATAWIDTH),
    .N_INPUTS  (N_INPUTS),
    .SELWIDTH  (SELWIDTH)
  ) u_mux (
    .in_array (bank),
    .sel      (idx),
    .out      (out_data)
  );

endmodule

// File: tb/tb_result_drain_ctrl.sv
// Randomised self-checking bench for result_drain_ctrl
// against a beat-list model of the batch.
module tb_result_drain_ctrl;

  typedef logic [7:0][15:0] words_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  words_t       in_array = '0;
  logic         start = 1'b0;
  logic [3:0]   num_words = '0;
  logic [15:0]  out_data;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [2:0]   sel;
  logic         busy;
  logic         done;

  int n_checks = 0;
  int n_fail   = 0;

  result_drain_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_array  (in_array),
    .start     (start),
    .num_words (num_words),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sel       (sel),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  function automatic words_t rand_words();
    words_t w;
    for (int i = 0; i < 8; i++) w[i] = 16'($urandom);
    return w;
  endfunction

  // mode 0: ready high, 1: random ready, 2: fixed 1,0,0,1,0,1,1
  task automatic run_batch(input string nm, input words_t w,
                           input int nw, input int mode,
                           input bit poke);
    int k;
    int j;
    int cyc;
    int p;
    int pat [7];
    logic r;
    logic [21:0] got;
    logic [21:0] exp;
    logic [5:0]  sgot;
    logic [5:0]  sexp;
    pat = '{1, 0, 0, 1, 0, 1, 1};
    k = (nw > 8) ? 8 : nw;
    j = 0;
    cyc = 0;
    p = 0;
    @(negedge clk);
    in_array  = w;
    num_words = 4'(nw);
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (poke) in_array = {8{16'hFFFF}};
    while (j < k && cyc < 200) begin
      got = {out_valid, busy, done, sel, out_data};
      exp = {1'b1, 1'b1, 1'b0, 3'(j), w[j]};
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL %s beat%0d: got %h want %h", nm, j, got, exp);
      end
      if (mode == 0)      r = 1'b1;
      else if (mode == 2) r = (p < 7) ? pat[p][0] : 1'b1;
      else                r = (cyc > 40) ? 1'b1 : 1'($urandom);
      p++;
      out_ready = r;
      start = poke && (j == 1);
      if (r) j++;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    if (cyc >= 200) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s timeout: got %0d beats want %0d", nm, j, k);
    end
    sgot = {out_valid, busy, done, sel};
    sexp = {1'b0, 1'b1, 1'b1, 3'((k > 0) ? k - 1 : 0)};
    n_checks++;
    if (sgot !== sexp) begin
      n_fail++;
      $display("FAIL %s done: got %b want %b", nm, sgot, sexp);
    end
    @(negedge clk);
    sgot = {out_valid, busy, done, sel};
    sexp = 6'b000_000;
    n_checks++;
    if (sgot !== sexp) begin
      n_fail++;
      $display("FAIL %s idle: got %b want %b", nm, sgot, sexp);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [21:0] got;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    got = {out_valid, busy, done, sel, out_data};
    n_checks++;
    if (got !== 22'h0) begin
      n_fail++;
      $display("FAIL reset: got %h want %h", got, 22'h0);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_full_drain();
    words_t w;
    for (int i = 0; i < 8; i++) w[i] = 16'(i);
    run_batch("full", w, 8, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    run_batch("bp", rand_words(), 4, 2, 1'b0);
  endtask

  task automatic test_clamp_zero();
    run_batch("clamp", rand_words(), 12, 0, 1'b0);
    run_batch("clamp15", rand_words(), 15, 1, 1'b0);
    run_batch("zero", rand_words(), 0, 0, 1'b0);
  endtask

  task automatic test_snapshot();
    run_batch("snap", rand_words(), 6, 0, 1'b1);
    run_batch("snap_bp", rand_words(), 8, 1, 1'b1);
  endtask

  task automatic test_async_reset();
    words_t w;
    logic [21:0] got;
    logic [21:0] exp;
    w = rand_words();
    @(negedge clk);
    in_array  = w;
    num_words = 4'd8;
    start     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int b = 0; b < 3; b++) begin
      got = {out_valid, busy, done, sel, out_data};
      exp = {3'b110, 3'(b), w[b]};
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL arst beat%0d: got %h want %h", b, got, exp);
      end
      @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    got = {out_valid, busy, done, sel, out_data};
    n_checks++;
    if (got !== 22'h0) begin
      n_fail++;
      $display("FAIL arst now: got %h want %h", got, 22'h0);
    end
    @(negedge clk);
    got = {out_valid, busy, done, sel, out_data};
    n_checks++;
    if (got !== 22'h0) begin
      n_fail++;
      $display("FAIL arst hold: got %h want %h", got, 22'h0);
    end
    rst_n = 1'b1;
    out_ready = 1'b0;
    run_batch("post_rst", rand_words(), 8, 0, 1'b0);
  endtask

  task automatic test_random();
    for (int t = 0; t < 8; t++) begin
      run_batch("rand", rand_words(), int'($urandom_range(0, 15)),
                int'($urandom_range(0, 1)), 1'($urandom));
    end
  endtask

  task automatic test_back_to_back();
    run_batch("b2b_a", rand_words(), 3, 0, 1'b0);
    run_batch("b2b_b", rand_words(), 1, 0, 1'b0);
    run_batch("b2b_c", rand_words(), 2, 1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_full_drain();
    test_backpressure();
    test_clamp_zero();
    test_snapshot();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/result_drain_ctrl.md
Name: result_drain_ctrl

Overview:
- Sequencer that drains one batch of systolic-array results, N_INPUTS words of DATAWIDTH bits, onto a single valid/ready output stream.
- On `start` it snapshots the result row into a local bank, so the array is free to begin the next tile.
- It then steps an internal mux select through the bank in index order, one beat per accepted handshake.
- It sits between the array's result row and the downstream writeback/output FIFO.

Parameters:
- DATAWIDTH, 16, bit width of each result word and of out_data.
- N_INPUTS, 8, number of result words per batch (bank depth).
- SELWIDTH, 3, width of the select/index; must be >= $clog2(N_INPUTS).
- CNTWIDTH, 4, width of num_words; must be >= $clog2(N_INPUTS+1).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_array  input  DATAWIDTH x N_INPUTS  result words from the array; sampled only on an accepted start.
- start  input  1  single-cycle request to capture in_array and begin draining.
- num_words  input  CNTWIDTH  number of words to drain, sampled with start.
- out_data  output  DATAWIDTH  current beat data.
- out_valid  output  1  beat valid.
- out_ready  input  1  downstream accepts the beat when out_valid && out_ready.
- sel  output  SELWIDTH  index of the word currently presented (debug/observability).
- busy  output  1  high while not IDLE.
- done  output  1  one-cycle pulse after the last beat is accepted.

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values: state=IDLE, idx=0, bank all zeros, cnt=0, out_valid=0, done=0, busy=0, sel=0, out_data=bank[0]=0.
  - Reset asserted mid-stream aborts immediately.
  - No done pulse is produced, and the partial batch is discarded.
- States: IDLE, STREAM, DONE.
- IDLE:
  - start=1 captures the bank with bank[i] <= in_array[i] for all i.
  - It also sets cnt <= min(num_words, N_INPUTS) and idx <= 0.
  - If the clamped count is 0, go to DONE. Otherwise go to STREAM.
- STREAM:
  - out_valid=1, out_data=bank[idx] (via the mux sub-module), sel=idx.
  - On handshake (out_valid && out_ready):
    - if idx==cnt-1, go to DONE and drop out_valid;
    - otherwise idx <= idx+1.
  - Without handshake, out_data, sel and out_valid hold stable (AXI-style; valid never retracts).
- DONE: done=1 for exactly one cycle, then go to IDLE with idx <= 0.
- busy = (state != IDLE); it is high in STREAM and DONE.
- Latency: start to first out_valid is 1 cycle.
- Throughput: 1 beat per cycle while out_ready=1. A batch of k words with ready held high takes k STREAM cycles plus 1 DONE cycle.
- start while busy is ignored; there is no queuing and no bank update. start in the DONE cycle is also ignored.
- in_array changes after capture have no effect on the batch in flight.
- num_words > N_INPUTS is clamped to N_INPUTS. idx never exceeds cnt-1, so no index wraps past the bank.
- All outputs are driven from registers through the mux only. There is no combinational path from in_array, start or num_words to any output. out_ready has no combinational path to outputs.

Decomposition:
- Shared package (systolic_pkg): typedef enum logic [1:0] {IDLE, STREAM, DONE} drain_state_t.
- The package also holds shared DATAWIDTH/N_INPUTS defaults so array, mux and controller agree.
- One sub-module: the existing mux, instantiated with in_array=bank, sel=idx, out=out_data. The controller owns only the FSM, index counter and bank registers.

Test Plan:
- Full drain, ready always 1:
  - Stimulus: in_array = {0x0007..0x0000} (word i = i), num_words=8, start pulse.
  - Response: out_valid from the next cycle, 8 consecutive beats 0x0000..0x0007 with sel 0..7, then done for 1 cycle. busy high for 9 cycles.
- Backpressure:
  - Stimulus: num_words=4, out_ready toggled 1,0,0,1,0,1,1.
  - Response: out_data and sel stable during ready=0; beats 0,1,2,3 each delivered once and in order; done after the 4th handshake.
- Clamp and zero:
  - num_words=12 gives exactly 8 beats.
  - num_words=0 gives no out_valid, busy high 1 cycle, and a done pulse 1 cycle after start.
- Snapshot isolation and ignored start:
  - Stimulus: change in_array to 0xFFFF and pulse start during STREAM.
  - Response: the remaining beats carry the originally captured values, and no second batch starts.
- Async reset mid-stream:
  - Stimulus: assert rst_n=0 after 3 beats of an 8-word batch, between clock edges.
  - Response: out_valid, busy and sel go to 0 immediately, no done pulse, bank reads 0. A new start after release drains normally from index 0.
